// File: rtl/mac_pkg.sv
// Shared encodings for the MAC operand feeder: CPU-side and MAC-side
// command codes plus the front-end state encoding.
package mac_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int N_WIDTH_DEFAULT    = 2;

  typedef enum logic [1:0] {
    CPU_PUSH  = 2'd0,
    CPU_SYNC  = 2'd1,
    CPU_READ  = 2'd2,
    CPU_CLEAR = 2'd3
  } cpu_cmd_e;

  typedef enum logic [1:0] {
    MAC_CLEAR = 2'd0,
    MAC_ADD   = 2'd1,
    MAC_READ  = 2'd2
  } mac_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_WAIT,
    ST_DRAIN,
    ST_ISSUE_CMD,
    ST_WAIT_CMD,
    ST_RESP
  } fe_state_e;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Custom-instruction handshake shared by the CPU port and the MAC port:
// the master drives command/operands, the slave answers with result/done.
interface mac_operand_feeder_if #(
  parameter int DATA_WIDTH = mac_pkg::DATA_WIDTH_DEFAULT,
  parameter int N_WIDTH    = mac_pkg::N_WIDTH_DEFAULT
);
  logic                  clk_en;
  logic                  start;
  logic [N_WIDTH-1:0]    n;
  logic [DATA_WIDTH-1:0] dataa;
  logic [DATA_WIDTH-1:0] datab;
  logic [DATA_WIDTH-1:0] result;
  logic                  done;

  modport master (output clk_en, start, n, dataa, datab, input result, done);
  modport slave  (input clk_en, start, n, dataa, datab, output result, done);
endinterface

// File: rtl/mac_pair_fifo.sv
// Operand-pair FIFO: registered storage, head captured into a register on
// pop so the popped pair stays stable on the MAC operand bus.
module mac_pair_fifo #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write in the same cycle its head is popped.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        head   <= mem[rd_ptr];
      end
      count <= count + (ADDR_WIDTH+1)'(do_push) - (ADDR_WIDTH+1)'(do_pop);
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Queues CPU operand pairs and feeds them to the MAC as ADDs; READ, CLEAR
// and SYNC wait for the queue and the MAC to drain before completing.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int N_WIDTH    = N_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic aclr_n,
  mac_operand_feeder_if.slave  cpu,
  mac_operand_feeder_if.master mac
);

  localparam int PAIR_WIDTH = 2 * DATA_WIDTH;

  fe_state_e             state;
  cpu_cmd_e              cmd_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  mac_busy;

  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [PAIR_WIDTH-1:0] push_data;
  logic [PAIR_WIDTH-1:0] head;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   occ_after_push;

  logic                  accept;
  logic                  push_idle;
  logic                  push_wait;
  logic                  drain_done;
  logic                  fe_issue;

  assign accept     = cpu.clk_en & cpu.start & (state == ST_IDLE);
  assign push_idle  = accept & (cpu_cmd_e'(cpu.n) == CPU_PUSH) & ~full;
  assign pop        = ~empty & ~mac_busy & (state != ST_ISSUE_CMD);
  assign push_wait  = (state == ST_PUSH_WAIT) & (~full | pop);
  assign push       = push_idle | push_wait;
  assign push_data  = (state == ST_PUSH_WAIT) ? {a_q, b_q} : {cpu.dataa, cpu.datab};
  // Occupancy reported to the CPU already accounts for a pop on the same edge.
  assign occ_after_push = count + (ADDR_WIDTH+1)'(1) - (ADDR_WIDTH+1)'(pop);
  assign drain_done = empty & ~mac_busy;
  assign fe_issue   = (state == ST_DRAIN) & drain_done & (cmd_q != CPU_SYNC);

  assign mac.dataa = head[PAIR_WIDTH-1:DATA_WIDTH];
  assign mac.datab = head[DATA_WIDTH-1:0];

  mac_pair_fifo #(
    .WIDTH      (PAIR_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= ST_IDLE;
      cmd_q      <= CPU_PUSH;
      a_q        <= '0;
      b_q        <= '0;
      cpu.result <= '0;
      cpu.done   <= 1'b0;
    end else begin
      cpu.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q <= cpu_cmd_e'(cpu.n);
            a_q   <= cpu.dataa;
            b_q   <= cpu.datab;
            if (cpu_cmd_e'(cpu.n) == CPU_PUSH) begin
              if (push_idle) begin
                cpu.result <= DATA_WIDTH'(occ_after_push);
                cpu.done   <= 1'b1;
                state      <= ST_RESP;
              end else begin
                state <= ST_PUSH_WAIT;
              end
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_PUSH_WAIT: begin
          if (push_wait) begin
            cpu.result <= DATA_WIDTH'(occ_after_push);
            cpu.done   <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            if (cmd_q == CPU_SYNC) begin
              cpu.result <= '0;
              cpu.done   <= 1'b1;
              state      <= ST_RESP;
            end else begin
              state <= ST_ISSUE_CMD;
            end
          end
        end
        ST_ISSUE_CMD: state <= ST_WAIT_CMD;
        ST_WAIT_CMD: begin
          if (mac.done) begin
            cpu.result <= mac.result;
            cpu.done   <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Issue engine: one MAC command in flight; the front-end command is
  // launched on the DRAIN->ISSUE_CMD edge so mac_start is high in ISSUE_CMD.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      mac_busy   <= 1'b0;
      mac.start  <= 1'b0;
      mac.clk_en <= 1'b0;
      mac.n      <= '0;
    end else begin
      mac.start  <= 1'b0;
      mac.clk_en <= 1'b0;
      if (pop) begin
        mac.start  <= 1'b1;
        mac.clk_en <= 1'b1;
        mac.n      <= N_WIDTH'(MAC_ADD);
        mac_busy   <= 1'b1;
      end else if (fe_issue) begin
        mac.start  <= 1'b1;
        mac.clk_en <= 1'b1;
        mac.n      <= (cmd_q == CPU_READ) ? N_WIDTH'(MAC_READ) : N_WIDTH'(MAC_CLEAR);
        mac_busy   <= 1'b1;
      end else if (mac.done) begin
        mac_busy <= 1'b0;
      end
    end
  end

endmodule
